mem_store_bridge: RTL and testbench

Downstream consumer of the core's store port (`mem_addr`, `mem_data`, `mem_we`). Decodes each store into a data-RAM write or an I/O write. Data-RAM writes leave through a registered port. I/O writes are buffered in a small FIFO and drained to a slow peripheral over a valid/ready handshake. The core cannot stall, so a store that finds the FIFO full is dropped and reported through a sticky overflow flag.

---
 rtl/mem_store_bridge_if.sv | 45 ++++
 rtl/mem_store_bridge.sv | 133 +++++++++++++
 tb/tb_mem_store_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_bridge_if.sv
// Store-port / RAM-port / I/O-port bundle for mem_store_bridge.
// STORE_BRIDGE_DROP_CNT_EN adds the io_drop_cnt signal.
interface mem_store_bridge_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      mem_addr;
   logic [31:0]      mem_data;
   logic             mem_we;
   logic             ram_we;
   logic [31:0]      ram_addr;
   logic [31:0]      ram_data;
   logic             io_valid;
   logic             io_ready;
   logic [7:0]       io_addr;
   logic [31:0]      io_data;
   logic             io_ovf;
   logic [CNT_W-1:0] io_count;
`ifdef STORE_BRIDGE_DROP_CNT_EN
   logic [7:0]       io_drop_cnt;

   modport slave (
      input  mem_addr, mem_data, mem_we, io_ready,
      output ram_we, ram_addr, ram_data, io_valid, io_addr, io_data,
             io_ovf, io_count, io_drop_cnt
   );
   modport master (
      output mem_addr, mem_data, mem_we, io_ready,
      input  ram_we, ram_addr, ram_data, io_valid, io_addr, io_data,
             io_ovf, io_count, io_drop_cnt
   );
`else
   modport slave (
      input  mem_addr, mem_data, mem_we, io_ready,
      output ram_we, ram_addr, ram_data, io_valid, io_addr, io_data,
             io_ovf, io_count
   );
   modport master (
      output mem_addr, mem_data, mem_we, io_ready,
      input  ram_we, ram_addr, ram_data, io_valid, io_addr, io_data,
             io_ovf, io_count
   );
`endif
endinterface

// File: rtl/mem_store_bridge.sv
// Splits core stores into a registered data-RAM port and a queued I/O port.
// STORE_BRIDGE_DROP_CNT_EN adds an 8-bit saturating count of dropped I/O stores.
module mem_store_bridge #(
   parameter int unsigned DEPTH   = 4,
   parameter logic [23:0] IO_PAGE = 24'h000001
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_store_bridge_if.slave bus
);
   localparam int unsigned PTR_W      = $clog2(DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;
   localparam logic [7:0]  CTL_OFFSET = 8'hFF;

   logic             ram_we_q, ram_we_d;
   logic [31:0]      ram_addr_q, ram_addr_d;
   logic [31:0]      ram_data_q, ram_data_d;
   logic [7:0]       fifo_addr_q [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
`ifdef STORE_BRIDGE_DROP_CNT_EN
   logic [7:0]       drop_cnt_q, drop_cnt_d;
`endif

   logic io_hit_c, ctl_hit_c, io_st_c, full_c, push_c, pop_c, drop_c;

   // Decode, FIFO control and next-state
   always_comb begin
      io_hit_c   = 1'b0;
      ctl_hit_c  = 1'b0;
      io_st_c    = 1'b0;
      full_c     = 1'b0;
      push_c     = 1'b0;
      pop_c      = 1'b0;
      drop_c     = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
`ifdef STORE_BRIDGE_DROP_CNT_EN
      drop_cnt_d = drop_cnt_q;
`endif

      io_hit_c  = bus.mem_we && (bus.mem_addr[31:8] == IO_PAGE);
      ctl_hit_c = io_hit_c && (bus.mem_addr[7:0] == CTL_OFFSET);
      io_st_c   = io_hit_c && !ctl_hit_c;
      full_c    = (count_q == CNT_W'(DEPTH));
      pop_c     = valid_q && bus.io_ready;
      push_c    = io_st_c && (!full_c || pop_c);
      drop_c    = io_st_c && !push_c;

      if (bus.mem_we && !io_hit_c) begin
         ram_we_d   = 1'b1;
         ram_addr_d = bus.mem_addr;
         ram_data_d = bus.mem_data;
      end

      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      valid_d = (count_d != '0);

      // Control store and drop are exclusive: one store per cycle
      if (ctl_hit_c) begin
         ovf_d = 1'b0;
`ifdef STORE_BRIDGE_DROP_CNT_EN
         drop_cnt_d = '0;
`endif
      end else if (drop_c) begin
         ovf_d = 1'b1;
`ifdef STORE_BRIDGE_DROP_CNT_EN
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
      end
   end

   // State registers and FIFO storage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef STORE_BRIDGE_DROP_CNT_EN
         drop_cnt_q <= '0;
`endif
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
`ifdef STORE_BRIDGE_DROP_CNT_EN
         drop_cnt_q <= drop_cnt_d;
`endif
         if (push_c) begin
            fifo_addr_q[wr_ptr_q] <= bus.mem_addr[7:0];
            fifo_data_q[wr_ptr_q] <= bus.mem_data;
         end
      end
   end

   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_data = ram_data_q;
   assign bus.io_valid = valid_q;
   assign bus.io_addr  = fifo_addr_q[rd_ptr_q];
   assign bus.io_data  = fifo_data_q[rd_ptr_q];
   assign bus.io_ovf   = ovf_q;
   assign bus.io_count = count_q;
`ifdef STORE_BRIDGE_DROP_CNT_EN
   assign bus.io_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_mem_store_bridge.sv
// Scoreboard bench for mem_store_bridge: a negedge model predicts every output.
module tb_mem_store_bridge;
   localparam int unsigned DEPTH   = 4;
   localparam logic [23:0] IO_PAGE = 24'h000001;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_store_bridge_if #(.DEPTH(DEPTH)) bus ();

   mem_store_bridge #(.DEPTH(DEPTH), .IO_PAGE(IO_PAGE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model state, advanced at each negedge for the coming posedge
   logic [39:0] sb_q [$];
   logic        m_ovf      = 1'b0;
   logic        m_ram_we   = 1'b0;
   logic [31:0] m_ram_addr = '0;
   logic [31:0] m_ram_data = '0;
   logic [7:0]  m_drop     = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         m_ovf    = 1'b0;
         m_ram_we = 1'b0;
         m_drop   = '0;
      end else begin
         check_eq("io_count", 32'(bus.io_count), 32'(sb_q.size()));
         check_eq("io_valid", 32'(bus.io_valid), 32'(sb_q.size() != 0));
         check_eq("io_ovf", 32'(bus.io_ovf), 32'(m_ovf));
         check_eq("ram_we", 32'(bus.ram_we), 32'(m_ram_we));
`ifdef STORE_BRIDGE_DROP_CNT_EN
         check_eq("io_drop_cnt", 32'(bus.io_drop_cnt), 32'(m_drop));
`endif
         if (m_ram_we) begin
            check_eq("ram_addr", bus.ram_addr, m_ram_addr);
            check_eq("ram_data", bus.ram_data, m_ram_data);
         end
         if (sb_q.size() != 0) begin
            check_eq("head_addr", 32'(bus.io_addr), 32'(sb_q[0][39:32]));
            check_eq("head_data", bus.io_data, sb_q[0][31:0]);
            if (bus.io_ready) void'(sb_q.pop_front());
         end
         m_ram_we = 1'b0;
         if (bus.mem_we) begin
            if (bus.mem_addr[31:8] == IO_PAGE) begin
               if (bus.mem_addr[7:0] == 8'hFF) begin
                  m_ovf  = 1'b0;
                  m_drop = '0;
               end else if (sb_q.size() < DEPTH) begin
                  sb_q.push_back({bus.mem_addr[7:0], bus.mem_data});
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
               end
            end else begin
               m_ram_we   = 1'b1;
               m_ram_addr = bus.mem_addr;
               m_ram_data = bus.mem_data;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      bus.mem_addr = addr;
      bus.mem_data = data;
      bus.mem_we   = 1'b1;
      idle(1);
      bus.mem_we   = 1'b0;
   endtask

   task automatic drain();
      bus.io_ready = 1'b1;
      for (int i = 0; i < 40 && bus.io_count != 0; i++) idle(1);
      check_eq("drain_empty", 32'(bus.io_count), 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_data = '0;
      bus.io_ready = 1'b0;
      idle(3);
      rst_n = 1'b1;

      check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
      check_eq("rst_ram_addr", bus.ram_addr, 32'd0);
      check_eq("rst_ram_data", bus.ram_data, 32'd0);
      check_eq("rst_io_valid", 32'(bus.io_valid), 32'd0);
      check_eq("rst_io_addr", 32'(bus.io_addr), 32'd0);
      check_eq("rst_io_data", bus.io_data, 32'd0);
      check_eq("rst_io_ovf", 32'(bus.io_ovf), 32'd0);
      check_eq("rst_io_count", 32'(bus.io_count), 32'd0);
      idle(1);

      // RAM store: one-cycle write pulse
      store(32'h10, 32'hDEADBEEF);
      check_eq("ram_pulse_we", 32'(bus.ram_we), 32'd1);
      check_eq("ram_pulse_addr", bus.ram_addr, 32'h10);
      check_eq("ram_pulse_data", bus.ram_data, 32'hDEADBEEF);
      check_eq("ram_no_io", 32'(bus.io_valid), 32'd0);
      idle(1);
      check_eq("ram_pulse_end", 32'(bus.ram_we), 32'd0);

      // Fill, overflow, ordered drain
      for (int i = 0; i < 4; i++) store(32'h100 + 32'(i), 32'(i + 1));
      check_eq("fill_count", 32'(bus.io_count), 32'd4);
      check_eq("fill_head_addr", 32'(bus.io_addr), 32'h00);
      check_eq("fill_head_data", bus.io_data, 32'd1);
      store(32'h104, 32'd5);
      check_eq("ovf_set", 32'(bus.io_ovf), 32'd1);
      check_eq("ovf_count", 32'(bus.io_count), 32'd4);
      drain();

      // Push and pop while full
      bus.io_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(32'h110 + 32'(i), 32'(11 + i));
      bus.io_ready = 1'b1;
      store(32'h120, 32'd9);
      check_eq("fullpp_count", 32'(bus.io_count), 32'd4);
      check_eq("fullpp_ovf", 32'(bus.io_ovf), 32'd1);
      check_eq("fullpp_head", bus.io_data, 32'd12);
      drain();

      // Control write clears overflow without touching queued entries
      bus.io_ready = 1'b0;
      store(32'h130, 32'd21);
      store(32'h131, 32'd22);
      store(32'h1FF, 32'd0);
      check_eq("clr_ovf", 32'(bus.io_ovf), 32'd0);
      check_eq("clr_count", 32'(bus.io_count), 32'd2);
      check_eq("clr_head", bus.io_data, 32'd21);
`ifdef STORE_BRIDGE_DROP_CNT_EN
      check_eq("clr_drop_cnt", 32'(bus.io_drop_cnt), 32'd0);
`endif

      // Reset with queued entries
      store(32'h132, 32'd23);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check_eq("rstmid_valid", 32'(bus.io_valid), 32'd0);
      check_eq("rstmid_count", 32'(bus.io_count), 32'd0);
      store(32'h140, 32'h55);
      check_eq("rstmid_new_valid", 32'(bus.io_valid), 32'd1);
      check_eq("rstmid_new_addr", 32'(bus.io_addr), 32'h40);
      check_eq("rstmid_new_data", bus.io_data, 32'h55);
      drain();

      // Random mix of RAM, I/O and control stores with random backpressure
      for (int i = 0; i < 300; i++) begin
         int unsigned kind;
         kind = $urandom_range(0, 9);
         bus.io_ready = 1'($urandom_range(0, 1));
         if (kind <= 1)      store($urandom() & 32'hFFFF_F0FF | 32'h0000_0200, $urandom());
         else if (kind == 2) store(32'h1FF, $urandom());
         else if (kind <= 8) store(32'h100 + 32'($urandom_range(0, 254)), $urandom());
         else                idle(1);
      end
      drain();

`ifdef STORE_BRIDGE_DROP_CNT_EN
      // Drop counter saturation
      bus.io_ready = 1'b0;
      for (int i = 0; i < 300; i++) store(32'h100 + 32'(i % 200), 32'(1000 + i));
      check_eq("sat_drop_cnt", 32'(bus.io_drop_cnt), 32'hFF);
      check_eq("sat_count", 32'(bus.io_count), 32'd4);
      check_eq("sat_ovf", 32'(bus.io_ovf), 32'd1);
      store(32'h1FF, 32'd0);
      check_eq("sat_clr_drop", 32'(bus.io_drop_cnt), 32'd0);
      check_eq("sat_clr_ovf", 32'(bus.io_ovf), 32'd0);
      drain();
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
